// File: rtl/serial_adder_ctrl_if.sv
// Operand/result bundle for the bit-serial adder controller.
// Handshake: the master raises start with operands; they are taken on the first edge with busy=0.
// The result is valid in the single cycle where done=1 and is held until the next accepted start.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] operand_A;
    logic [WIDTH-1:0] operand_B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;

    modport master (
        output start, operand_A, operand_B,
        input  busy, done, result, carry_out
    );

    modport slave (
        input  start, operand_A, operand_B,
        output busy, done, result, carry_out
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared 1-bit full adder (two half adders plus carry OR)
// is stepped LSB-first over WIDTH cycles, with a start/busy/done handshake.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    serial_adder_ctrl_if.slave  bus,
    output logic [1:0]          dbg_state
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-2:0] sh_r;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_out_r;

    logic ha0_s, ha0_c, ha1_s, ha1_c;
    logic sum_bit, carry_nxt;
    logic [WIDTH-1:0] sum_word;

    assign ha0_s     = sh_a[0] ^ sh_b[0];
    assign ha0_c     = sh_a[0] & sh_b[0];
    assign ha1_s     = ha0_s ^ carry;
    assign ha1_c     = ha0_s & carry;
    assign sum_bit   = ha1_s;
    assign carry_nxt = ha0_c | ha1_c;

    // Result bits enter from the MSB side; after the last step the word is complete.
    assign sum_word = {sum_bit, sh_r};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sh_a        <= '0;
            sh_b        <= '0;
            sh_r        <= '0;
            cnt         <= '0;
            carry       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_r    <= '0;
            carry_out_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        sh_a   <= bus.operand_A;
                        sh_b   <= bus.operand_B;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= ADD;
                    end else begin
                        state  <= IDLE;
                    end
                end
                ADD: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    sh_r  <= sum_word[WIDTH-1:1];
                    carry <= carry_nxt;
                    if (cnt == LAST) begin
                        result_r    <= sum_word;
                        carry_out_r <= carry_nxt;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.result    = result_r;
    assign bus.carry_out = carry_out_r;
    assign dbg_state     = state;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random check of serial_adder_ctrl at WIDTH=8 with a queue-based scoreboard.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_state;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int         total = 0;
    int         bad = 0;
    logic [W:0] exp_q[$];
    int         t_q[$];
    logic [W:0] held = '0;
    int         done_seen = 0;
    int         busy_run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples 2 time units after each rising edge.
    always begin
        logic [W:0] e;
        int         t;
        @(posedge clk);
        #2;
        check("busy_and_done", 64'(bus.busy & bus.done), 64'd0);
        if (reset) begin
            busy_run = 0;
        end else if (bus.busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            check("busy_len", 64'(busy_run), 64'(W));
            busy_run = 0;
        end
        if (bus.done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(bus.done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                t = t_q.pop_front();
                held = e;
                check("sum", 64'({bus.carry_out, bus.result}), 64'(e));
                check("latency", 64'(cyc - t), 64'(W));
            end
        end else begin
            check("hold", 64'({bus.carry_out, bus.result}), 64'(held));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] e);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.operand_A = a;
        bus.operand_B = b;
        exp_q.push_back(e);
        t_q.push_back(cyc + 1);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.operand_A = W'($urandom);
        bus.operand_B = W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            t_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   e;
    } vec_t;

    vec_t vecs[3] = '{
        '{8'h35, 8'h4A, 9'h07F},
        '{8'hFF, 8'h01, 9'h100},
        '{8'hFF, 8'hFF, 9'h1FE}
    };

    initial begin
        int snap;
        int n;
        logic [W-1:0] ra, rb;

        bus.start     = 1'b0;
        bus.operand_A = '0;
        bus.operand_B = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_carry", 64'(bus.carry_out), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);

        // basic and overflow vectors
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].e);
            check("add_state", 64'(dbg_state), 64'd1);
            drain();
        end

        // start during ADD is ignored
        snap = done_seen;
        issue(8'h10, 8'h20, 9'h030);
        repeat (2) @(negedge clk);
        bus.start     = 1'b1;
        bus.operand_A = 8'hAA;
        bus.operand_B = 8'h55;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (W + 2) @(negedge clk);
        check("no_second_done", 64'(done_seen), 64'(snap + 1));

        // back-to-back: start held, second op accepted in the DONE cycle
        @(negedge clk);
        bus.start     = 1'b1;
        bus.operand_A = 8'h01;
        bus.operand_B = 8'h02;
        exp_q.push_back(9'h003);
        t_q.push_back(cyc + 1);
        n = 0;
        @(negedge clk);
        while (!bus.done && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_done", 64'(bus.done), 64'd1);
        bus.operand_A = 8'h80;
        bus.operand_B = 8'h80;
        exp_q.push_back(9'h100);
        t_q.push_back(cyc + 1);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy", 64'(bus.busy), 64'd1);
        repeat (3) @(negedge clk);
        check("b2b_hold", 64'(bus.result), 64'h03);
        drain();

        // reset in the middle of an operation
        repeat (2) @(negedge clk);
        snap = done_seen;
        issue(8'hF0, 8'h0F, 9'h0FF);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        held  = '0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        t_q.delete();
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_result", 64'({bus.carry_out, bus.result}), 64'd0);
        check("abort_state", 64'(dbg_state), 64'd0);
        repeat (2 * W) @(negedge clk);
        check("abort_no_done", 64'(done_seen), 64'(snap));
        issue(8'h02, 8'h03, 9'h005);
        drain();

        // random sweep
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            issue(ra, rb, {1'b0, ra} + {1'b0, rb});
            drain();
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
